// File: rtl/immgen_pkg.sv
// immgen_pkg: shared format codes, opcodes, occupancy states and entry layout for imm_decode_stage.
package immgen_pkg;
  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ZIMM  = 3'd7
  } imm_fmt_e;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam int XLEN_MAX = 64;
  // Widest (RV64) entry layout; the stage narrows the address fields to DATA_WIDTH.
  typedef struct packed {
    logic [31:0]         inst;
    logic [XLEN_MAX-1:0] pc;
    logic [XLEN_MAX-1:0] imm;
    imm_fmt_e            fmt;
    logic [XLEN_MAX-1:0] pc_rel;
    logic                illegal;
  } imm_entry_t;
endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational format decode, immediate extension and pc+imm.
// Build option IMMGEN_ZICSR_EN adds the SYSTEM zimm (CSR immediate) format.
module imm_decode
  import immgen_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           inst,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] imm,
  output logic [DATA_WIDTH-1:0] pc_rel,
  output imm_fmt_e              fmt,
  output logic                  illegal
);
  localparam int W = DATA_WIDTH;
  localparam bit RV64 = (DATA_WIDTH == 64);
  logic [6:0] opc;
  logic [2:0] f3;
  logic       sh_op;
  logic [5:0] shamt;
  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign sh_op = (f3[1:0] == 2'b01);
  // Only the RV64 OP-IMM shifts carry a sixth shamt bit; bit 30 selects arithmetic and is never immediate.
  assign shamt = (RV64 && opc == OPC_OP_IMM) ? inst[25:20] : {1'b0, inst[24:20]};
  always_comb begin
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opc)
      OPC_LOAD, OPC_JALR: fmt = FMT_I;
      OPC_OP_IMM:         fmt = sh_op ? FMT_SHAMT : FMT_I;
      OPC_OP_IMM_32: begin
        fmt     = !RV64 ? FMT_NONE : sh_op ? FMT_SHAMT : FMT_I;
        illegal = !RV64;
      end
      OPC_STORE:          fmt = FMT_S;
      OPC_BRANCH:         fmt = FMT_B;
      OPC_LUI, OPC_AUIPC: fmt = FMT_U;
      OPC_JAL:            fmt = FMT_J;
      OPC_OP, OPC_OP_32:  fmt = FMT_NONE;
`ifdef IMMGEN_ZICSR_EN
      OPC_SYSTEM:         fmt = f3[2] ? FMT_ZIMM : FMT_NONE;
`else
      OPC_SYSTEM:         fmt = FMT_NONE;
`endif
      default:            illegal = 1'b1;
    endcase
  end
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:     imm = W'($signed(inst[31:20]));
      FMT_S:     imm = W'($signed({inst[31:25], inst[11:7]}));
      FMT_B:     imm = W'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      FMT_U:     imm = W'($signed({inst[31:12], 12'b0}));
      FMT_J:     imm = W'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      FMT_SHAMT: imm = W'(shamt);
`ifdef IMMGEN_ZICSR_EN
      FMT_ZIMM:  imm = W'(inst[19:15]);
`endif
      default:   imm = '0;
    endcase
  end
  assign pc_rel = pc + imm;
endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered immediate decode behind a valid/ready two-entry skid buffer.
// Build option IMMGEN_ZICSR_EN enables the SYSTEM zimm format in the decoder.
module imm_decode_stage
  import immgen_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [DATA_WIDTH-1:0] in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_inst,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [2:0]            out_fmt,
  output logic [DATA_WIDTH-1:0] out_pc_rel,
  output logic                  out_illegal
);
  typedef struct packed {
    logic [31:0]           inst;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] imm;
    imm_fmt_e              fmt;
    logic [DATA_WIDTH-1:0] pc_rel;
    logic                  illegal;
  } entry_t;
  entry_t                dec, main_q, skid_q;
  occ_e                  st, st_nxt;
  logic                  acc, drn;
  logic [DATA_WIDTH-1:0] d_imm, d_rel;
  imm_fmt_e              d_fmt;
  logic                  d_ill;
  imm_decode #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
    .inst   (in_inst),
    .pc     (in_pc),
    .imm    (d_imm),
    .pc_rel (d_rel),
    .fmt    (d_fmt),
    .illegal(d_ill)
  );
  assign dec       = '{inst: in_inst, pc: in_pc, imm: d_imm, fmt: d_fmt, pc_rel: d_rel, illegal: d_ill};
  assign in_ready  = (st != TWO);
  assign out_valid = (st != EMPTY);
  assign acc       = in_valid & in_ready & !flush;
  assign drn       = out_valid & out_ready & !flush;
  always_comb begin
    st_nxt = st;
    case (st)
      EMPTY:   st_nxt = acc ? ONE : EMPTY;
      ONE:     st_nxt = (acc & !drn) ? TWO : (!acc & drn) ? EMPTY : ONE;
      default: st_nxt = drn ? ONE : TWO;
    endcase
    if (flush) st_nxt = EMPTY;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st     <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      st <= st_nxt;
      if (st == TWO && drn) main_q <= skid_q;
      else if (acc && (st == EMPTY || drn)) main_q <= dec;
      if (acc && st == ONE && !drn) skid_q <= dec;
    end
  end
  assign out_inst    = main_q.inst;
  assign out_pc      = main_q.pc;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_pc_rel  = main_q.pc_rel;
  assign out_illegal = main_q.illegal;
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: random and directed stimulus against a FIFO/arithmetic reference model.
module tb_imm_decode_stage;
  localparam int W = 32;
  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, out_ready;
  logic [31:0]   in_inst;
  logic [W-1:0]  in_pc;
  logic          in_ready, out_valid, out_illegal;
  logic [31:0]   out_inst;
  logic [W-1:0]  out_pc, out_imm, out_pc_rel;
  logic [2:0]    out_fmt;
  logic          v64, rdy64, ir64, ov64, ill64;
  logic [31:0]   inst64, oinst64;
  logic [63:0]   pc64, opc64, imm64, rel64;
  logic [2:0]    fmt64;
  typedef struct {
    logic [31:0]  inst;
    logic [W-1:0] pc;
    logic [W-1:0] imm;
    int           fmt;
    bit           ill;
  } exp_t;
  exp_t q[$];
  int   n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  imm_decode_stage #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_pc_rel(out_pc_rel), .out_illegal(out_illegal)
  );
  imm_decode_stage #(.DATA_WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(v64), .in_ready(ir64),
    .in_inst(inst64), .in_pc(pc64), .out_valid(ov64), .out_ready(rdy64),
    .out_inst(oinst64), .out_pc(opc64), .out_imm(imm64), .out_fmt(fmt64),
    .out_pc_rel(rel64), .out_illegal(ill64)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Reference decode straight from the ISA field layouts, using signed integer arithmetic.
  function automatic exp_t ref_dec(input logic [31:0] i, input logic [W-1:0] pc);
    exp_t e;
    longint v = 0;
    int f = 0;
    bit ill = 0;
    case (i[6:0])
      7'h03, 7'h67: f = 1;
      7'h13: f = (i[14:12] == 3'd1 || i[14:12] == 3'd5) ? 6 : 1;
      7'h1b: ill = 1;
      7'h23: f = 2;
      7'h63: f = 3;
      7'h37, 7'h17: f = 4;
      7'h6f: f = 5;
      7'h33, 7'h3b: f = 0;
`ifdef IMMGEN_ZICSR_EN
      7'h73: f = (i[14:12] >= 3'd4) ? 7 : 0;
`else
      7'h73: f = 0;
`endif
      default: ill = 1;
    endcase
    case (f)
      1: begin v = longint'(i[31:20]); if (v >= 2048) v -= 4096; end
      2: begin v = longint'({i[31:25], i[11:7]}); if (v >= 2048) v -= 4096; end
      3: begin v = longint'({i[31], i[7], i[30:25], i[11:8]}) * 2; if (v >= 4096) v -= 8192; end
      4: begin v = longint'(i[31:12]) * 4096; if (i[31]) v -= 64'h1_0000_0000; end
      5: begin v = longint'({i[31], i[19:12], i[20], i[30:21]}) * 2; if (v >= 1048576) v -= 2097152; end
      6: v = longint'(i[24:20]);
      7: v = longint'(i[19:15]);
      default: v = 0;
    endcase
    e.inst = i;
    e.pc   = pc;
    e.imm  = v[W-1:0];
    e.fmt  = f;
    e.ill  = ill;
    return e;
  endfunction
  task automatic check_outputs();
    logic [W-1:0] rel;
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      rel = q[0].pc + q[0].imm;
      chk("out_inst", 64'(out_inst), 64'(q[0].inst));
      chk("out_pc", 64'(out_pc), 64'(q[0].pc));
      chk("out_imm", 64'(out_imm), 64'(q[0].imm));
      chk("out_fmt", 64'(out_fmt), 64'(q[0].fmt));
      chk("out_pc_rel", 64'(out_pc_rel), 64'(rel));
      chk("out_illegal", 64'(out_illegal), 64'(q[0].ill));
    end
  endtask
  // Drive one cycle, advance the model, then compare at the following falling edge.
  task automatic cyc(input bit v, input logic [31:0] i, input logic [W-1:0] pc, input bit ordy,
                     input bit fl = 0, input bit rn = 1);
    bit acc, drn;
    in_valid = v; in_inst = i; in_pc = pc; out_ready = ordy; flush = fl; rst_n = rn;
    acc = v && q.size() < 2;
    drn = q.size() > 0 && ordy;
    if (!rn || fl) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(ref_dec(i, pc));
    end
    @(negedge clk);
    check_outputs();
  endtask
  logic [6:0] ops [12] = '{7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h13, 7'h1b, 7'h33, 7'h3b, 7'h37, 7'h17, 7'h73};
  initial begin
    logic [31:0] r;
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 0; in_inst = 0; in_pc = 0;
    v64 = 0; rdy64 = 1; inst64 = 0; pc64 = 0;
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_out_inst", 64'(out_inst), 0);
    chk("rst_out_pc", 64'(out_pc), 0);
    chk("rst_out_imm", 64'(out_imm), 0);
    chk("rst_out_fmt", 64'(out_fmt), 0);
    chk("rst_out_pc_rel", 64'(out_pc_rel), 0);
    chk("rst_out_illegal", 64'(out_illegal), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    cyc(0, 0, 0, 1);
    cyc(1, 32'hFFF00093, 'h100, 1);
    chk("addi_valid", 64'(out_valid), 1);
    chk("addi_imm", 64'(out_imm), 64'hFFFFFFFF);
    chk("addi_fmt", 64'(out_fmt), 1);
    chk("addi_pc_rel", 64'(out_pc_rel), 64'h000000FF);
    cyc(1, 32'h4010D093, 'h104, 1);
    chk("srai_imm", 64'(out_imm), 1);
    chk("srai_fmt", 64'(out_fmt), 6);
    cyc(1, 32'hFE000EE3, 'h200, 1);
    chk("beq_imm", 64'(out_imm), 64'hFFFFFFFC);
    chk("beq_fmt", 64'(out_fmt), 3);
    chk("beq_pc_rel", 64'(out_pc_rel), 64'h1FC);
    cyc(1, 32'h0010006F, 'h300, 1);
    chk("jal_imm", 64'(out_imm), 64'h800);
    chk("jal_fmt", 64'(out_fmt), 5);
    cyc(1, 32'h300FD073, 'h304, 1);
`ifdef IMMGEN_ZICSR_EN
    chk("csrrwi_imm", 64'(out_imm), 31);
    chk("csrrwi_fmt", 64'(out_fmt), 7);
`else
    chk("csrrwi_imm", 64'(out_imm), 0);
    chk("csrrwi_fmt", 64'(out_fmt), 0);
`endif
    chk("csrrwi_illegal", 64'(out_illegal), 0);
    cyc(1, 32'h00000000, 'h308, 1);
    chk("zero_illegal", 64'(out_illegal), 1);
    chk("zero_fmt", 64'(out_fmt), 0);
    v64 = 1; inst64 = 32'h800000B7; pc64 = 64'h1000;
    cyc(0, 0, 0, 1);
    chk("lui64_imm", imm64, 64'hFFFFFFFF80000000);
    chk("lui64_fmt", 64'(fmt64), 4);
    chk("lui64_pc_rel", rel64, 64'hFFFFFFFF80001000);
    inst64 = 32'h4200D093;
    cyc(0, 0, 0, 1);
    chk("srai64_imm", imm64, 64'h20);
    chk("srai64_fmt", 64'(fmt64), 6);
    inst64 = 32'hFFF0009B;
    cyc(0, 0, 0, 1);
    chk("addiw64_imm", imm64, 64'hFFFFFFFFFFFFFFFF);
    chk("addiw64_illegal", 64'(ill64), 0);
    v64 = 0;
    cyc(1, 32'h00500093, 'h400, 0);
    cyc(1, 32'h00600113, 'h404, 0);
    chk("bp_in_ready_low", 64'(in_ready), 0);
    cyc(1, 32'h00700193, 'h408, 0);
    chk("bp_hold_a", 64'(out_inst), 64'h00500093);
    cyc(1, 32'h00700193, 'h408, 1);
    chk("bp_second_b", 64'(out_inst), 64'h00600113);
    chk("bp_in_ready_up", 64'(in_ready), 1);
    cyc(1, 32'h00700193, 'h408, 1);
    chk("bp_third_c", 64'(out_inst), 64'h00700193);
    cyc(0, 0, 0, 1);
    chk("bp_empty", 64'(out_valid), 0);
    cyc(1, 32'h00500093, 'h500, 0);
    cyc(1, 32'h00600113, 'h504, 0);
    cyc(1, 32'h00700193, 'h508, 0, 1);
    chk("flush_valid", 64'(out_valid), 0);
    chk("flush_ready", 64'(in_ready), 1);
    cyc(0, 0, 0, 1);
    chk("flush_nothing", 64'(out_valid), 0);
    cyc(1, 32'h00500093, 'h600, 0);
    cyc(1, 32'h00600113, 'h604, 0);
    cyc(1, 32'h00700193, 'h608, 0, 0, 0);
    chk("rstmid_valid", 64'(out_valid), 0);
    chk("rstmid_ready", 64'(in_ready), 1);
    cyc(0, 0, 0, 1);
    chk("rstmid_nothing", 64'(out_valid), 0);
    for (int k = 0; k < 3000; k++) begin
      r = $urandom();
      if ($urandom_range(9) != 0) r[6:0] = ops[$urandom_range(11)];
      cyc($urandom_range(3) != 0, r, W'($urandom()), $urandom_range(2) != 0,
          $urandom_range(39) == 0, $urandom_range(79) != 0);
    end
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, parametrised successor to the combinational immediate generator: decodes the instruction format, produces the sign- or zero-extended immediate at `DATA_WIDTH` (RV32 or RV64), and precomputes the PC-relative sum. It sits between fetch and the register-read stage behind a valid/ready handshake with a two-entry skid buffer, so `in_ready` never depends combinationally on `out_ready`.

## Interface
- `DATA_WIDTH`, 32, datapath width; legal values 32 and 64.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous active-low reset
- `flush`  in  1  drop all buffered entries
- `in_valid`  in  1  upstream entry valid
- `in_ready`  out  1  stage can accept an entry
- `in_inst`  in  32  raw instruction
- `in_pc`  in  DATA_WIDTH  instruction PC
- `out_valid`  out  1  output entry valid
- `out_ready`  in  1  downstream accepts
- `out_inst`  out  32  instruction, passed through
- `out_pc`  out  DATA_WIDTH  PC, passed through
- `out_imm`  out  DATA_WIDTH  extended immediate
- `out_fmt`  out  3  `imm_fmt_e` format code
- `out_pc_rel`  out  DATA_WIDTH  `out_pc + out_imm`, modulo 2^DATA_WIDTH
- `out_illegal`  out  1  `inst[1:0] != 2'b11` or unsupported opcode

## Operation
- Format by `opcode = inst[6:0]`:
  - LOAD, JALR, OP-IMM → I. OP-IMM-32 (`0011011`) → I only when `DATA_WIDTH==64`; otherwise illegal.
  - OP-IMM with funct3 001/101, and OP-IMM-32 with those funct3 values → SHAMT. The immediate is the zero-extended `inst[24:20]` (`inst[25:20]` for OP-IMM at 64). Bit 30 is never part of the immediate.
  - STORE → S. BRANCH → B, with bit0=0. LUI/AUIPC → U, `{inst[31:12],12'b0}` sign-extended from bit 31. JAL → J, with bit0=0.
  - OP and OP-32 → NONE, imm 0. SYSTEM: see Configuration.
  - Anything else → NONE, imm 0, `out_illegal=1`.
- Sign extension for I/S/B/U/J is from the instruction's bit 31 up to DATA_WIDTH.
- All outputs are registered. Decode is performed before the skid register, so both entries hold decoded results.
- Transfer: in on `in_valid & in_ready`; out on `out_valid & out_ready`. Entries leave in FIFO order, with no loss and no duplication.
- Storage is a main register plus a skid register. `in_ready = !skid_valid`.
- Entry states:
  - EMPTY → ONE on accept.
  - ONE → TWO on accept without drain.
  - TWO → ONE on drain; the skid entry moves into the main register.
  - Simultaneous accept and drain in ONE stays in ONE with the new entry.
- `flush` has priority over everything. Next cycle: `out_valid=0`, `in_ready=1`. An input presented in the flush cycle is discarded.

## Timing
- Latency is 1 cycle from accept to `out_valid` when the stage is empty. Throughput is 1 per cycle while `out_ready=1`.
- Reset values: `out_valid=0`, `in_ready=1` (skid empty), and 0 on `out_inst`, `out_pc`, `out_imm`, `out_fmt` (NONE), `out_pc_rel` and `out_illegal`.
- No transfer occurs in any cycle with `rst_n=0`. Reset mid-stream discards both entries.
- Output payload is stable while `out_valid & !out_ready`.
- `in_ready` falls the cycle after the second entry is captured with no drain. It rises the cycle after a drain empties the skid register.

## Configuration
- `IMMGEN_ZICSR_EN` defined:
  - SYSTEM with `funct3[2]=1` → ZIMM, imm = zero-extended `inst[19:15]`.
  - SYSTEM with `funct3[2]=0` → NONE, imm 0.
- Macro undefined: all SYSTEM → NONE, imm 0. No ZIMM logic is synthesised.
- `out_illegal` is 0 for SYSTEM in both builds.

## Structure
- Package `immgen_pkg` holds:
  - `imm_fmt_e`: NONE=0, I=1, S=2, B=3, U=4, J=5, SHAMT=6, ZIMM=7.
  - Opcode localparams.
  - Packed struct `imm_entry_t` {inst, pc, imm, fmt, pc_rel, illegal}.
- Sub-module `imm_decode` holds the combinational format decode, extension and pc_rel. The parent owns the handshake and the main/skid registers.

## Test plan
- DATA_WIDTH=32, `0xFFF00093` (addi -1), pc `0x100` → imm `0xFFFFFFFF`, fmt I, pc_rel `0x000000FF`, one cycle after accept.
- `0x4010D093` (srai x1,x1,1) → imm `1`, fmt SHAMT. `0xFE000EE3` (beq −4) at pc `0x200` → imm `0xFFFFFFFC`, fmt B, pc_rel `0x1FC`.
- `0x0010006F` (jal +2048) → imm `0x800`, fmt J. DATA_WIDTH=64, `0x800000B7` (lui) → imm `0xFFFFFFFF80000000`, fmt U.
- `0x300FD073` (csrrwi zimm 31):
  - With macro → imm 31, fmt ZIMM.
  - Without macro → imm 0, fmt NONE.
  - Either build → illegal 0.
  - `0x00000000` → illegal 1.
- `out_ready=0`, three back-to-back inputs → two accepted, `in_ready=0` from the following cycle. Raise `out_ready` → outputs appear in order, third input accepted.
- Two entries buffered, assert `flush` together with `in_valid` → next cycle `out_valid=0`, `in_ready=1`, nothing delivered. A reset pulse mid-stream gives the same result.
